// File: rtl/fir_output_capture_if.sv
// Stream, golden-load, readback and result signals of the FIR output capture block.
interface fir_output_capture_if #(
    parameter int N  = 32,
    parameter int AW = 7
);
    logic            start;
    logic            in_valid;
    logic [N-1:0]    data_in;
    logic            gold_we;
    logic [AW-1:0]   gold_addr;
    logic [N-1:0]    gold_wdata;
    logic [AW-1:0]   rd_addr;
    logic [N-1:0]    rd_data;
    logic            busy;
    logic            done;
    logic [AW:0]     count;
    logic [N+AW:0]   err_sum;
    logic [N:0]      max_err;

    modport master (
        output start, in_valid, data_in, gold_we, gold_addr, gold_wdata, rd_addr,
        input  rd_data, busy, done, count, err_sum, max_err
    );

    modport slave (
        input  start, in_valid, data_in, gold_we, gold_addr, gold_wdata, rd_addr,
        output rd_data, busy, done, count, err_sum, max_err
    );
endinterface

// File: rtl/fir_output_capture.sv
// FIR output sink: drops warm-up samples, captures S words, and scores them
// against a golden sequence (sum and peak of absolute error).
module fir_output_capture #(
    parameter int N    = 32,
    parameter int S    = 128,
    parameter int AW   = 7,
    parameter int TAPS = 4
) (
    input logic                clk,
    input logic                reset,
    fir_output_capture_if.slave io
);
    typedef enum logic [1:0] {IDLE, WARMUP, CAPTURE, DONE} state_t;

    localparam int WW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [WW-1:0] WARM_LAST = WW'((TAPS > 1) ? TAPS - 2 : 0);
    localparam logic [AW:0]   CNT_LAST  = (AW + 1)'(S - 1);
    localparam logic [AW:0]   S_CNT     = (AW + 1)'(S);

    state_t            state, state_nxt;
    logic              run_start, capture;
    logic [WW-1:0]     warm_cnt;
    logic [AW:0]       count;
    logic [N+AW:0]     err_sum;
    logic [N:0]        max_err;
    logic [N-1:0]      rd_data;

    logic [N-1:0]      buffer [0:(2**AW)-1];
    logic [N-1:0]      golden [0:(2**AW)-1];

    logic [AW-1:0]     wr_idx;
    logic [N-1:0]      gold_q;
    logic [N:0]        diff, abs_err;

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (io.start) begin
                    run_start = 1'b1;
                    state_nxt = (TAPS > 1) ? WARMUP : CAPTURE;
                end
            end
            WARMUP: begin
                if (io.in_valid && warm_cnt == WARM_LAST) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (io.in_valid) begin
                    capture = 1'b1;
                    if (count == CNT_LAST) state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sign-extend both operands to N+1 bits so the difference never wraps.
    always_comb begin
        wr_idx  = count[AW-1:0];
        gold_q  = golden[wr_idx];
        diff    = {io.data_in[N-1], io.data_in} - {gold_q[N-1], gold_q};
        abs_err = diff[N] ? (~diff + 1'b1) : diff;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            warm_cnt <= '0;
            count    <= '0;
            err_sum  <= '0;
            max_err  <= '0;
            rd_data  <= '0;
        end else begin
            state   <= state_nxt;
            rd_data <= ({1'b0, io.rd_addr} < S_CNT) ? buffer[io.rd_addr] : '0;
            if (run_start) begin
                warm_cnt <= '0;
                count    <= '0;
                err_sum  <= '0;
                max_err  <= '0;
            end
            if (state == WARMUP && io.in_valid) warm_cnt <= warm_cnt + 1'b1;
            if (capture) begin
                count   <= count + 1'b1;
                err_sum <= err_sum + {{AW{1'b0}}, abs_err};
                if (abs_err > max_err) max_err <= abs_err;
            end
        end
    end

    // Memories are never cleared; golden accepts writes even during reset.
    always_ff @(posedge clk) begin
        if (capture && !reset) buffer[wr_idx] <= io.data_in;
        if (io.gold_we) golden[io.gold_addr] <= io.gold_wdata;
    end

    assign io.busy    = (state == WARMUP) || (state == CAPTURE);
    assign io.done    = (state == DONE);
    assign io.count   = count;
    assign io.err_sum = err_sum;
    assign io.max_err = max_err;
    assign io.rd_data = rd_data;
endmodule

// File: tb/tb_fir_output_capture.sv
// Self-checking bench: run-level reference model compared every cycle, plus
// hand-computed expectations for each directed scenario.
module tb_fir_output_capture;
    localparam int N = 32, S = 128, AW = 7, TAPS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fir_output_capture_if #(.N(N), .AW(AW)) a ();
    fir_output_capture_if #(.N(8), .AW(2))  b ();

    fir_output_capture #(.N(N), .S(S), .AW(AW), .TAPS(TAPS)) dut (
        .clk(clk), .reset(reset), .io(a.slave)
    );
    fir_output_capture #(.N(8), .S(3), .AW(2), .TAPS(1)) dut1 (
        .clk(clk), .reset(reset), .io(b.slave)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: phase 0 idle, 1 dropping warm-up, 2 capturing, 3 finished.
    int          m_phase = 0, m_drop = 0, m_cnt = 0;
    longint      m_sum = 0, m_max = 0;
    logic [31:0] mgold [S];
    logic [31:0] mbuf  [S];
    bit          mknown[S];
    logic [31:0] m_rd = '0;
    bit          m_rd_known = 1'b1;

    always @(posedge clk) begin
        longint e;
        if (reset) begin
            m_phase = 0; m_cnt = 0; m_sum = 0; m_max = 0;
            m_rd = '0; m_rd_known = 1'b1;
        end else begin
            if (int'(a.rd_addr) >= S) begin
                m_rd = '0; m_rd_known = 1'b1;
            end else begin
                m_rd = mbuf[a.rd_addr]; m_rd_known = mknown[a.rd_addr];
            end
            case (m_phase)
                0, 3: if (a.start) begin
                    m_cnt = 0; m_sum = 0; m_max = 0;
                    m_drop = TAPS - 1;
                    m_phase = (m_drop > 0) ? 1 : 2;
                end
                1: if (a.in_valid) begin
                    m_drop--;
                    if (m_drop == 0) m_phase = 2;
                end
                2: if (a.in_valid) begin
                    e = longint'(signed'(a.data_in)) - longint'(signed'(mgold[m_cnt]));
                    if (e < 0) e = -e;
                    mbuf[m_cnt] = a.data_in; mknown[m_cnt] = 1'b1;
                    m_sum += e;
                    if (e > m_max) m_max = e;
                    m_cnt++;
                    if (m_cnt == S) m_phase = 3;
                end
                default: ;
            endcase
        end
        if (a.gold_we) mgold[a.gold_addr] = a.gold_wdata;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",    a.busy,    (m_phase == 1 || m_phase == 2) ? 1 : 0);
            chk("done",    a.done,    (m_phase == 3) ? 1 : 0);
            chk("count",   a.count,   m_cnt);
            chk("err_sum", a.err_sum, m_sum);
            chk("max_err", a.max_err, m_max);
            if (m_rd_known) chk("rd_data", a.rd_data, m_rd);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic gold_fill(input logic [31:0] v);
        for (int i = 0; i < S; i++) begin
            a.gold_we = 1'b1; a.gold_addr = AW'(i); a.gold_wdata = v;
            step();
        end
        a.gold_we = 1'b0;
    endtask

    task automatic run(input logic [31:0] first, input logic [31:0] rest, input bit stall,
                       input bit follow, input bit collide, input int n_cap);
        int total;
        total = (TAPS - 1) + n_cap;
        a.start = 1'b1; step(); a.start = 1'b0;
        for (int i = 0; i < total; i++) begin
            a.in_valid = 1'b1;
            a.data_in  = (i < TAPS - 1) ? 32'hDEAD_BEEF : ((i == TAPS - 1) ? first : rest);
            if (follow && i >= TAPS - 1) a.rd_addr = AW'(i - (TAPS - 1));
            if (collide && i == TAPS - 1) begin
                a.gold_we = 1'b1; a.gold_addr = '0; a.gold_wdata = 32'h20;
            end
            if (stall && i == total - 1) chk("done_before_last", a.done, 0);
            step();
            a.in_valid = 1'b0; a.gold_we = 1'b0;
            if (stall && i != total - 1) begin
                a.start = 1'b1; step(); a.start = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a.start = 0; a.in_valid = 0; a.data_in = '0; a.gold_we = 0;
        a.gold_addr = '0; a.gold_wdata = '0; a.rd_addr = '0;
        b.start = 0; b.in_valid = 0; b.data_in = '0; b.gold_we = 0;
        b.gold_addr = '0; b.gold_wdata = '0; b.rd_addr = '0;
        step(); step();
        reset = 1'b0;
        step();
        chk_en = 1'b1;
        chk("rst_busy", a.busy, 0);   chk("rst_done", a.done, 0);
        chk("rst_count", a.count, 0); chk("rst_err_sum", a.err_sum, 0);
        chk("rst_max_err", a.max_err, 0); chk("rst_rd_data", a.rd_data, 0);

        // Basic continuous run
        gold_fill(32'h20);
        run(32'h20, 32'h20, 0, 0, 0, S);
        chk("basic_done", a.done, 1);      chk("basic_count", a.count, 128);
        chk("basic_err_sum", a.err_sum, 0); chk("basic_max_err", a.max_err, 0);
        a.rd_addr = 7'd5; step();
        chk("basic_rd5", a.rd_data, 32'h20);

        // Signed error, readback following the write pointer
        a.gold_we = 1'b1; a.gold_addr = '0; a.gold_wdata = 32'hFFFF_FFFF; step(); a.gold_we = 1'b0;
        run(32'h1, 32'h20, 0, 1, 0, S);
        chk("signed_err_sum", a.err_sum, 2); chk("signed_max_err", a.max_err, 2);

        // Golden write colliding with capture of sample 0 uses old golden (-1)
        run(32'hFFFF_FFFF, 32'h20, 0, 0, 1, S);
        chk("collide_err_sum", a.err_sum, 0);

        // Extreme error
        gold_fill(32'h8000_0000);
        run(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0, S);
        chk("extreme_err_sum", a.err_sum, 64'h7F_FFFF_FF80);
        chk("extreme_max_err", a.max_err, 64'hFFFF_FFFF);

        // in_valid in DONE is ignored
        for (int i = 0; i < 3; i++) begin
            a.in_valid = 1'b1; a.data_in = 32'h1234; step();
        end
        a.in_valid = 1'b0;
        chk("done_hold_count", a.count, 128);
        chk("done_hold_err", a.err_sum, 64'h7F_FFFF_FF80);

        // Stalled stream with start pulses while busy
        gold_fill(32'h20);
        run(32'h20, 32'h20, 1, 0, 0, S);
        chk("stall_done", a.done, 1); chk("stall_count", a.count, 128);
        chk("stall_err_sum", a.err_sum, 0);

        // Reset mid-capture at count 50, then a full run
        run(32'h25, 32'h20, 0, 0, 0, 50);
        chk("mid_count", a.count, 50);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_rst_busy", a.busy, 0);    chk("mid_rst_done", a.done, 0);
        chk("mid_rst_count", a.count, 0);  chk("mid_rst_err_sum", a.err_sum, 0);
        chk("mid_rst_max_err", a.max_err, 0);
        run(32'h20, 32'h20, 0, 0, 0, S);
        chk("rerun_done", a.done, 1); chk("rerun_count", a.count, 128);

        // TAPS=1, S=3 instance
        for (int i = 0; i < 4; i++) begin
            b.gold_we = 1'b1; b.gold_addr = 2'(i); b.gold_wdata = '0; step();
        end
        b.gold_we = 1'b0;
        b.start = 1'b1; b.in_valid = 1'b1; b.data_in = 8'h55; step(); b.start = 1'b0;
        chk("t1_busy", b.busy, 1); chk("t1_count0", b.count, 0);
        for (int k = 0; k < 3; k++) begin
            b.data_in = 8'(8'h11 * (k + 1)); step();
        end
        b.in_valid = 1'b0;
        chk("t1_done", b.done, 1);        chk("t1_count", b.count, 3);
        chk("t1_err_sum", b.err_sum, 8'h66); chk("t1_max_err", b.max_err, 8'h33);
        b.rd_addr = 2'd0; step();
        chk("t1_rd0", b.rd_data, 8'h11);
        b.rd_addr = 2'd3; step();
        chk("t1_rd_oob", b.rd_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
